// File: rtl/wb_stream_ctrl.sv
// wb_stream_ctrl: byte-stream to 8-bit Wishbone bridge.
// Command byte {we, xxx, adr[3:0]} (plus one data byte for writes) becomes a
// single bus cycle. Read data, or 0xFF on timeout, is returned as one response byte.
module wb_stream_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       stb,
    output logic       we,
    output logic [3:0] adr,
    output logic [7:0] dat_c,
    input  logic [7:0] dat_p,
    input  logic       ack,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        BUS  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Last counter value before abort. The counter holds 0 in the first stb
    // cycle, so a value of TIMEOUT-1 means stb has been high for TIMEOUT cycles.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic        stb_n, we_n, rx_ready_n, tx_valid_n, timeout_err_n;
    logic [3:0]  adr_n;
    logic [7:0]  dat_c_n, tx_data_n;
    logic        rx_fire;

    assign rx_fire = rx_valid & rx_ready;

    // State and all registered outputs; async reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            stb         <= 1'b0;
            we          <= 1'b0;
            adr         <= '0;
            dat_c       <= '0;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            stb         <= stb_n;
            we          <= we_n;
            adr         <= adr_n;
            dat_c       <= dat_c_n;
            rx_ready    <= rx_ready_n;
            tx_valid    <= tx_valid_n;
            tx_data     <= tx_data_n;
            timeout_err <= timeout_err_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        stb_n         = stb;
        we_n          = we;
        adr_n         = adr;
        dat_c_n       = dat_c;
        tx_valid_n    = tx_valid;
        tx_data_n     = tx_data;
        timeout_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (rx_fire) begin
                    we_n  = rx_data[7];
                    adr_n = rx_data[3:0];
                    if (rx_data[7]) begin
                        state_n = DATA;
                    end else begin
                        state_n = BUS;
                        stb_n   = 1'b1;
                        cnt_n   = '0;
                    end
                end
            end
            DATA: begin
                if (rx_fire) begin
                    dat_c_n = rx_data;
                    state_n = BUS;
                    stb_n   = 1'b1;
                    cnt_n   = '0;
                end
            end
            BUS: begin
                // ack takes priority over a timeout landing on the same edge
                if (ack) begin
                    stb_n = 1'b0;
                    if (we) begin
                        state_n = IDLE;
                    end else begin
                        tx_data_n  = dat_p;
                        tx_valid_n = 1'b1;
                        state_n    = RESP;
                    end
                end else if (cnt >= TO_LAST) begin
                    stb_n         = 1'b0;
                    timeout_err_n = 1'b1;
                    if (we) begin
                        state_n = IDLE;
                    end else begin
                        tx_data_n  = 8'hFF;
                        tx_valid_n = 1'b1;
                        state_n    = RESP;
                    end
                end else if (cnt != 16'hFFFF) begin
                    cnt_n = cnt + 16'd1;
                end
            end
            RESP: begin
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Ready only once IDLE/DATA has been occupied for a full cycle, which
        // guarantees a stb-low gap between back-to-back transactions.
        rx_ready_n = ((state == IDLE) || (state == DATA)) &&
                     ((state_n == IDLE) || (state_n == DATA));
    end

endmodule

// File: tb/tb_wb_stream_ctrl.sv
// Directed bench for wb_stream_ctrl (TIMEOUT=4). Expected response bytes are
// queued when a read is issued and checked when the response transfers.
module tb_wb_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       stb, we;
    logic [3:0] adr;
    logic [7:0] dat_c;
    logic [7:0] dat_p = '0;
    logic       ack = 1'b0;
    logic       timeout_err;

    int n_chk  = 0;
    int n_fail = 0;
    int n_to   = 0;
    logic [7:0] exp_q[$];

    wb_stream_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .stb(stb), .we(we), .adr(adr), .dat_c(dat_c),
        .dat_p(dat_p), .ack(ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a byte and hold it until accepted; returns just after the accept edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 50) begin
            tick();
            t++;
        end
        if (t >= 50) chki("rx_accept_timeout", t, 0);
        tick();
        rx_valid = 1'b0;
    endtask

    // Scoreboard: compare each transferred response against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) chki("unexpected_response", 1, 0);
            else chk8("resp_data", tx_data, exp_q.pop_front());
        end
    end

    // Count timeout pulses.
    always @(negedge clk) begin
        if (!rst && timeout_err) n_to++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, to0;

        // ---- reset state
        repeat (2) tick();
        chk1("rst_rx_ready", rx_ready, 1'b0);
        chk1("rst_stb", stb, 1'b0);
        chk1("rst_tx_valid", tx_valid, 1'b0);
        chk8("rst_tx_data", tx_data, 8'h00);
        chk8("rst_outs", {we, adr, dat_c[2:0]}, 8'h00);
        chk1("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        tick();
        chk1("idle_rx_ready", rx_ready, 1'b1);

        // ---- read, ack 2 cycles after stb rises
        exp_q.push_back(8'h5A);
        send_byte(8'h03);
        chk1("rd_stb_rise", stb, 1'b1);
        chk1("rd_we", we, 1'b0);
        chk8("rd_adr", {4'h0, adr}, 8'h03);
        chk1("rd_rx_ready_busy", rx_ready, 1'b0);
        tick();
        tick();
        chk1("rd_stb_held", stb, 1'b1);
        ack = 1'b1; dat_p = 8'h5A;
        tick();
        ack = 1'b0; dat_p = 8'h00;
        chk1("rd_stb_fall", stb, 1'b0);
        chk1("rd_tx_valid", tx_valid, 1'b1);
        chk8("rd_tx_data", tx_data, 8'h5A);
        repeat (3) tick();
        chk1("rd_tx_valid_held", tx_valid, 1'b1);
        chk8("rd_tx_data_held", tx_data, 8'h5A);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk1("rd_tx_valid_drop", tx_valid, 1'b0);
        tick();

        // ---- write, immediate ack; stray ack after stb falls is ignored
        send_byte(8'h8C);
        chk1("wr_stb_in_data", stb, 1'b0);
        chk1("wr_rx_ready_data", rx_ready, 1'b1);
        send_byte(8'hA7);
        chk1("wr_stb", stb, 1'b1);
        chk1("wr_we", we, 1'b1);
        chk8("wr_adr", {4'h0, adr}, 8'h0C);
        chk8("wr_dat_c", dat_c, 8'hA7);
        ack = 1'b1;
        tick();
        chk1("wr_stb_fall", stb, 1'b0);
        chk1("wr_no_tx", tx_valid, 1'b0);
        chk1("wr_rx_ready_gap", rx_ready, 1'b0);
        tick();
        ack = 1'b0;
        chk1("wr_rx_ready_back", rx_ready, 1'b1);
        chk1("wr_stray_ack_stb", stb, 1'b0);
        chk1("wr_stray_ack_tx", tx_valid, 1'b0);

        // ---- read timeout
        exp_q.push_back(8'hFF);
        to0 = n_to;
        send_byte(8'h01);
        n = 0;
        while (stb && n < 20) begin
            n++;
            tick();
        end
        chki("to_rd_stb_cycles", n, 4);
        chk1("to_rd_err_pulse", timeout_err, 1'b1);
        chk1("to_rd_tx_valid", tx_valid, 1'b1);
        chk8("to_rd_tx_data", tx_data, 8'hFF);
        tick();
        chk1("to_rd_err_clear", timeout_err, 1'b0);
        chki("to_rd_err_count", n_to - to0, 1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();

        // ---- write timeout
        to0 = n_to;
        send_byte(8'h81);
        send_byte(8'h00);
        n = 0;
        while (stb && n < 20) begin
            n++;
            tick();
        end
        chki("to_wr_stb_cycles", n, 4);
        repeat (3) begin
            chk1("to_wr_no_tx", tx_valid, 1'b0);
            tick();
        end
        chki("to_wr_err_count", n_to - to0, 1);

        // ---- ack in the final stb cycle, tx_ready already high
        exp_q.push_back(8'h33);
        to0 = n_to;
        send_byte(8'h02);
        repeat (3) tick();
        chk1("col_stb_4th", stb, 1'b1);
        ack = 1'b1; dat_p = 8'h33; tx_ready = 1'b1;
        tick();
        ack = 1'b0; dat_p = 8'h00;
        chk1("col_no_err", timeout_err, 1'b0);
        chk1("col_stb_fall", stb, 1'b0);
        chk8("col_tx_data", tx_data, 8'h33);
        tick();
        tx_ready = 1'b0;
        chk1("col_tx_done", tx_valid, 1'b0);
        chki("col_err_count", n_to - to0, 0);
        tick();

        // ---- response back-pressure with next command waiting
        exp_q.push_back(8'hC4);
        send_byte(8'h05);
        tick();
        ack = 1'b1; dat_p = 8'hC4;
        tick();
        ack = 1'b0; dat_p = 8'h00;
        rx_data = 8'h06; rx_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!tx_valid || tx_data !== 8'hC4 || rx_ready) begin
                chk1("bp_tx_valid", tx_valid, 1'b1);
                chk8("bp_tx_data", tx_data, 8'hC4);
                chk1("bp_rx_ready", rx_ready, 1'b0);
            end
            tick();
        end
        chk1("bp_stb_low", stb, 1'b0);
        chk1("bp_rx_blocked", rx_ready, 1'b0);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk1("bp_after_xfer_ready", rx_ready, 1'b0);
        exp_q.push_back(8'h11);
        send_byte(8'h06);
        chk1("bp_next_stb", stb, 1'b1);
        chk8("bp_next_adr", {4'h0, adr}, 8'h06);
        ack = 1'b1; dat_p = 8'h11;
        tick();
        ack = 1'b0; dat_p = 8'h00;
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();

        // ---- asynchronous reset while stb is high
        send_byte(8'h07);
        chk1("ar_stb_before", stb, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        chk1("ar_stb_async", stb, 1'b0);
        chk1("ar_rx_ready", rx_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk1("ar_idle_ready", rx_ready, 1'b1);
        chk1("ar_tx_valid", tx_valid, 1'b0);
        exp_q.push_back(8'h9E);
        send_byte(8'h09);
        chk1("ar_rd_stb", stb, 1'b1);
        tick();
        ack = 1'b1; dat_p = 8'h9E;
        tick();
        ack = 1'b0; dat_p = 8'h00;
        chk1("ar_rd_tx_valid", tx_valid, 1'b1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();

        chki("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stream_ctrl.md
Name: wb_stream_ctrl

Overview:
- Bus controller for the team's 8-bit Wishbone: turns a byte command stream (e.g. from UART RX) into single Wishbone read/write cycles, and returns read data as a byte stream (e.g. to UART TX).
- Drives the controller side of the bus: stb, we, adr[3:0], dat_c[7:0]. Consumes ack and dat_p from the peripheral side.
- One transaction is outstanding at a time.
- A timeout guards against peripherals that never acknowledge.

Parameters:
- TIMEOUT, default 255: bus cycles stb may stay high without ack before the controller aborts. Legal range is 1..65535. The counter is 16 bits wide.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- rx_data  input  8  command/data byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  the controller accepts rx_data this cycle.
- tx_data  output  8  response byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  the sink accepts tx_data this cycle.
- stb  output  1  Wishbone strobe.
- we  output  1  Wishbone write enable.
- adr  output  4  Wishbone address.
- dat_c  output  8  write data, controller to peripheral.
- dat_p  input  8  read data, peripheral to controller.
- ack  input  1  peripheral acknowledge; one-cycle pulse.
- timeout_err  output  1  one-cycle pulse when a transaction is aborted.

Behaviour:
- Reset is asynchronous, active-high. While rst is high, all outputs are 0 and the state is IDLE.
  - rx_ready=0, tx_valid=0, tx_data=0, stb=0, we=0, adr=0, dat_c=0, timeout_err=0.
  - Reset mid-transaction drops stb immediately and discards any pending byte or response.
- A byte transfers when rx_valid & rx_ready. A response transfers when tx_valid & tx_ready.
- Command byte format:
  - bit7 = we (1 = write, 0 = read).
  - bits3:0 = adr.
  - bits6:4 are ignored.
- All outputs are registered. stb, we, adr and dat_c are stable for the whole time stb is high.
- State machine:
  - IDLE: rx_ready=1. On accepting a command, latch we and adr.
    - we=1: go to DATA.
    - we=0: go to BUS; stb=1 from the next cycle.
  - DATA: rx_ready=1. On accepting a byte, latch it into dat_c and go to BUS; stb=1 from the next cycle.
  - BUS: rx_ready=0, stb=1, and the timeout counter increments each cycle.
    - Read, ack=1 sampled at an edge: stb=0 on the next cycle; tx_data captures dat_p on that same edge; tx_valid=1; go to RESP.
    - Write, ack=1 sampled at an edge: stb=0 next cycle; return to IDLE. Writes produce no response byte.
    - No ack within TIMEOUT cycles of stb high: stb=0 and timeout_err=1 for one cycle.
      - Read: go to RESP with tx_data=0xFF.
      - Write: return to IDLE.
  - RESP: rx_ready=0. tx_valid and tx_data are held until tx_ready=1. On the transfer edge, tx_valid=0 and go to IDLE.
- Timing:
  - Command accept to stb high: 1 cycle.
  - ack to stb low: 1 cycle.
  - ack to tx_valid (read): 1 cycle.
  - The earliest next command is accepted the cycle after returning to IDLE, so stb is low for at least 1 cycle between transactions.
- Simultaneous events and edge cases:
  - ack in the same cycle the counter reaches TIMEOUT: ack wins; no timeout_err; dat_p is used.
  - ack while stb=0 (including the cycle after stb falls): ignored.
  - tx_ready=1 in the same cycle tx_valid rises is a valid transfer.
  - The timeout counter clears on entry to BUS. It saturates, so there is no wrap-around.
  - rx_valid during BUS or RESP is back-pressured (rx_ready=0); the byte is not lost.

Test Plan:
- Read:
  - Send 0x03. The peripheral acks 2 cycles after stb rises with dat_p=0x5A.
  - Required: stb rises 1 cycle after accept, with we=0, adr=3. stb falls 1 cycle after ack. tx_valid=1 with tx_data=0x5A, held until tx_ready.
- Write:
  - Send 0x8C then 0xA7. The peripheral acks immediately.
  - Required: stb=1, we=1, adr=0xC, dat_c=0xA7 stable until ack. No tx_valid. Back in IDLE: rx_ready=1 two cycles after ack.
- Timeout:
  - TIMEOUT=4, send 0x01, never ack.
  - Required: stb high exactly 4 cycles. timeout_err pulses once. tx_data=0xFF.
  - Same run with write 0x81,0x00: timeout_err pulses once and there is no response.
- Ack/timeout collision:
  - TIMEOUT=4, ack arrives in the 4th stb cycle with dat_p=0x33.
  - Required: timeout_err=0, tx_data=0x33.
- Back-pressure:
  - Hold tx_ready=0 for 10 cycles after a read response while pushing the next command.
  - Required: tx_valid and tx_data stable; rx_ready=0. The next command is accepted only after the response transfers.
- Reset mid-operation:
  - Assert rst asynchronously while stb=1.
  - Required: stb=0 immediately, without waiting for a clock. After release, the state is IDLE and a fresh read completes normally.
